// File: rtl/player_pkg.sv
// Shared definitions for the player controller: state encoding, default sizing
// and command bit positions matching the button interface ordering.
package player_pkg;

    localparam int NUM_TRACKS_DEF  = 8;
    localparam int TRK_W_DEF       = 3;
    localparam int VOL_W_DEF       = 4;
    localparam int VOL_DEFAULT_DEF = 8;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_PLAY  = 2'd2,
        ST_PAUSE = 2'd3
    } state_e;

    localparam int CMD_PLAY_PAUSE = 0;
    localparam int CMD_VOL_UP     = 1;
    localparam int CMD_VOL_DOWN   = 2;
    localparam int CMD_FWD        = 3;
    localparam int CMD_BACK       = 4;
    localparam int CMD_W          = 5;

endpackage

// File: rtl/vol_sat_counter.sv
// Up/down counter that saturates at 0 and all-ones; simultaneous inc and dec
// cancel. Reset value is a parameter.
module vol_sat_counter #(
    parameter int           W       = 4,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/player_ctrl.sv
// Player controller: playback FSM, track index and volume driven by button pulses.
// Build option PLAYER_CTRL_LOOP_ALL_EN: end of last track reloads track 0 instead of stopping.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_STOP  | idle, run low; fwd/back browse the track index
// ST_LOAD  | load_req high for track_idx, waiting for load_ack
// ST_PLAY  | run high, engine plays samples
// ST_PAUSE | run low, track kept loaded; play/pause resumes without reload
module player_ctrl
    import player_pkg::*;
#(
    parameter int NUM_TRACKS  = NUM_TRACKS_DEF,
    parameter int TRK_W       = TRK_W_DEF,
    parameter int VOL_W       = VOL_W_DEF,
    parameter int VOL_DEFAULT = VOL_DEFAULT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_play_pause,
    input  logic             cmd_vol_up,
    input  logic             cmd_vol_down,
    input  logic             cmd_fwd,
    input  logic             cmd_back,
    input  logic             trk_done,
    input  logic             load_ack,
    output logic             load_req,
    output logic [TRK_W-1:0] load_trk,
    output logic             run,
    output logic [VOL_W-1:0] volume,
    output logic [TRK_W-1:0] track_idx,
    output logic [1:0]       state_o
);

    localparam logic [TRK_W-1:0] LAST_TRK = TRK_W'(NUM_TRACKS - 1);

`ifdef PLAYER_CTRL_LOOP_ALL_EN
    localparam state_e WRAP_STATE = ST_LOAD;
`else
    localparam state_e WRAP_STATE = ST_STOP;
`endif

    logic [CMD_W-1:0] cmd;
    state_e           state_q;
    logic [TRK_W-1:0] track_q;
    logic [TRK_W-1:0] trk_inc;
    logic [TRK_W-1:0] trk_dec;

    assign cmd = {cmd_back, cmd_fwd, cmd_vol_down, cmd_vol_up, cmd_play_pause};

    assign trk_inc = (track_q == LAST_TRK) ? '0 : track_q + 1'b1;
    assign trk_dec = (track_q == '0) ? LAST_TRK : track_q - 1'b1;

    // Priority within a cycle: play/pause > fwd > back > trk_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STOP;
            track_q <= '0;
        end else begin
            case (state_q)
                ST_STOP: begin
                    if (cmd[CMD_PLAY_PAUSE]) begin
                        state_q <= ST_LOAD;
                    end else if (cmd[CMD_FWD]) begin
                        track_q <= trk_inc;
                    end else if (cmd[CMD_BACK]) begin
                        track_q <= trk_dec;
                    end
                end
                ST_LOAD: begin
                    if (load_ack) begin
                        state_q <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (cmd[CMD_PLAY_PAUSE]) begin
                        state_q <= ST_PAUSE;
                    end else if (cmd[CMD_FWD]) begin
                        track_q <= trk_inc;
                        state_q <= ST_LOAD;
                    end else if (cmd[CMD_BACK]) begin
                        track_q <= trk_dec;
                        state_q <= ST_LOAD;
                    end else if (trk_done) begin
                        if (track_q == LAST_TRK) begin
                            track_q <= '0;
                            state_q <= WRAP_STATE;
                        end else begin
                            track_q <= track_q + 1'b1;
                            state_q <= ST_LOAD;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (cmd[CMD_PLAY_PAUSE]) begin
                        state_q <= ST_PLAY;
                    end else if (cmd[CMD_FWD]) begin
                        track_q <= trk_inc;
                        state_q <= ST_STOP;
                    end else if (cmd[CMD_BACK]) begin
                        track_q <= trk_dec;
                        state_q <= ST_STOP;
                    end
                end
                default: begin
                    state_q <= ST_STOP;
                end
            endcase
        end
    end

    vol_sat_counter #(
        .W       (VOL_W),
        .RST_VAL (VOL_W'(VOL_DEFAULT))
    ) u_vol (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (cmd[CMD_VOL_UP]),
        .dec_i (cmd[CMD_VOL_DOWN]),
        .cnt_o (volume)
    );

    // Derived from the state register so reset clears load_req without a clock.
    assign state_o   = state_q;
    assign run       = (state_q == ST_PLAY);
    assign load_req  = (state_q == ST_LOAD);
    assign load_trk  = track_q;
    assign track_idx = track_q;

endmodule
